seg7_scan_driver: RTL and testbench

//  Consumes the 16-bit value of four cascaded VCB4RE 4-bit counters: Q of stage k on data[4k+3:4k].

---
 rtl/seg7_pkg.sv | 13 +
 rtl/seg7_hex_decode.sv | 9 +
 rtl/seg7_scan_driver.sv | 66 ++++++
 tb/tb_seg7_scan_driver.sv | 101 ++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state encoding, blank constants and hex-to-segment table for the scan driver
package seg7_pkg;
  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_e;
  localparam logic [3:0] ALL_OFF_AN = 4'hF;
  localparam logic [6:0] ALL_OFF_SEG = 7'h7F;
  localparam logic [6:0] HEX2SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return HEX2SEG_TBL[nib];
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-low {g,f,e,d,c,b,a} segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex2seg(nib_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode hex scanner with shadow capture, blank window and leading-zero blanking
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] data,
  input  logic        load,
  input  logic        lz_en,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_tc
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [15:0] shadow_q;
  logic [CW-1:0] cnt_q;
  logic [1:0] idx_q;
  state_e state_q, state_d;
  logic [3:0] an_q, an_d, nz;
  logic [6:0] seg_q, seg_d, seg_w;
  logic dp_n_q, dp_n_d, tc_q, tc_d, slot_end, suppress, show;
  seg7_hex_decode u_dec (.nib_i(shadow_q[{idx_q, 2'b00} +: 4]), .seg_o(seg_w));
  // a digit above 0 is dark when it and every more-significant nibble are zero
  always_comb begin
    slot_end = cnt_q == CW'(REFRESH_DIV - 1);
    nz = {|shadow_q[15:12], |shadow_q[11:8], |shadow_q[7:4], |shadow_q[3:0]};
    suppress = lz_en && idx_q != 2'd0 && (nz >> idx_q) == 4'd0;
    state_d = slot_end ? BLANK :
              (state_q == BLANK && cnt_q == CW'(BLANK_CYC - 1)) ? DRIVE : state_q;
    show = state_q == DRIVE && !suppress;
    an_d = show ? ~(4'b0001 << idx_q) : ALL_OFF_AN;
    seg_d = show ? seg_w : ALL_OFF_SEG;
    dp_n_d = show ? ~dp[idx_q] : 1'b1;
    tc_d = idx_q == 2'd3 && slot_end;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      shadow_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      state_q <= BLANK;
      an_q <= ALL_OFF_AN;
      seg_q <= ALL_OFF_SEG;
      dp_n_q <= 1'b1;
      tc_q <= 1'b0;
    end else begin
      if (load) shadow_q <= data;
      cnt_q <= slot_end ? '0 : cnt_q + CW'(1);
      idx_q <= idx_q + {1'b0, slot_end};
      state_q <= state_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_n_q <= dp_n_d;
      tc_q <= tc_d;
    end
  end
  assign an = an_q;
  assign seg = seg_q;
  assign dp_n = dp_n_q;
  assign frame_tc = tc_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard bench against a slot-arithmetic reference model
module tb_seg7_scan_driver;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam logic [6:0] TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp_n;
    logic tc;
    logic care;
  } exp_t;
  logic clk = 1'b0;
  logic clr = 1'b1, load = 1'b0, lz_en = 1'b0;
  logic [15:0] data = '0;
  logic [3:0] dp = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp_n, frame_tc;
  exp_t q[$];
  int checks = 0, errors = 0;
  int p = 0;
  logic [15:0] sh = '0;
  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .clr(clr), .data(data), .load(load), .lz_en(lz_en), .dp(dp),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_tc(frame_tc)
  );
  always #10 clk = ~clk;
  // p is the scan position (cycles since reset) seen before the edge being predicted
  task automatic step(input logic c, input logic l, input logic [15:0] d, input logic lz, input logic [3:0] dpv);
    exp_t e;
    int cnt, idx;
    logic off;
    logic [3:0] nib;
    @(posedge clk);
    #1;
    clr = c; load = l; data = d; lz_en = lz; dp = dpv;
    if (c) begin
      e = '{4'hF, 7'h7F, 1'b1, 1'b0, 1'b1};
      p = 0;
      sh = '0;
    end else begin
      cnt = p % RD;
      idx = (p / RD) % 4;
      nib = sh[4*idx +: 4];
      off = cnt < BC || (lz && idx > 0 && (sh >> (4 * idx)) == 16'd0);
      e.an = off ? 4'hF : ~(4'b0001 << idx);
      e.seg = off ? 7'h7F : TBL[nib];
      e.dp_n = off ? 1'b1 : ~dpv[idx];
      e.tc = (p % (4 * RD)) == 4 * RD - 1;
      e.care = cnt < BC || !off;
      if (l) sh = d;
      p++;
    end
    q.push_back(e);
  endtask
  task automatic idle(input int n, input logic lz, input logic [3:0] dpv);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, lz, dpv);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() >= 2) begin
      e = q.pop_front();
      checks++;
      if (an !== e.an) begin errors++; $display("FAIL an got %b exp %b at %0t", an, e.an, $time); end
      checks++;
      if (frame_tc !== e.tc) begin errors++; $display("FAIL frame_tc got %b exp %b at %0t", frame_tc, e.tc, $time); end
      if (e.care) begin
        checks++;
        if (seg !== e.seg) begin errors++; $display("FAIL seg got %h exp %h at %0t", seg, e.seg, $time); end
        checks++;
        if (dp_n !== e.dp_n) begin errors++; $display("FAIL dp_n got %b exp %b at %0t", dp_n, e.dp_n, $time); end
      end
    end
  end
  initial begin
    repeat (3) step(1'b1, 1'b0, 16'h0000, 1'b0, 4'h0);
    step(1'b0, 1'b1, 16'h12A0, 1'b0, 4'h0);
    idle(39, 1'b0, 4'h0);
    step(1'b0, 1'b1, 16'h0005, 1'b1, 4'h0);
    idle(40, 1'b1, 4'h0);
    step(1'b0, 1'b1, 16'h0000, 1'b1, 4'h0);
    idle(40, 1'b1, 4'h0);
    step(1'b0, 1'b1, 16'hFFFF, 1'b0, 4'b0100);
    idle(40, 1'b0, 4'b0100);
    idle(96, 1'b0, 4'h0);
    while (p % (4 * RD) != 2 * RD + 4) step(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0);
    step(1'b1, 1'b1, 16'h9999, 1'b0, 4'h0);
    idle(16, 1'b0, 4'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, 16'($urandom),
           1'($urandom), 4'($urandom));
    idle(2, 1'b0, 4'h0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
